// File: rtl/slot_pkg.sv
// Shared types and default timing for the slot reel engine and its per-reel channels.
package slot_pkg;

  typedef enum logic [1:0] {
    ModeStop,
    ModeFast,
    ModeSlow
  } reel_mode_t;

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StSpin,
    StSettle,
    StResult,
    StDrain
  } engine_state_t;

  localparam int unsigned DefNumReels = 3;
  localparam int unsigned DefNumSyms  = 7;
  localparam int unsigned DefSymPitch = 90;
  localparam int unsigned DefFastDiv  = 131072;
  localparam int unsigned DefSlowDiv  = 4194304;
  localparam int unsigned DefStagger  = 33554432;
  localparam int unsigned DefMinSlow  = 32;

endpackage

// File: rtl/slot_reel_channel.sv
// One reel: step divider, {sym, phase} position counter, slow-step count and boundary snap.
module slot_reel_channel
  import slot_pkg::*;
#(
  parameter int unsigned NUM_SYMS  = DefNumSyms,
  parameter int unsigned SYM_PITCH = DefSymPitch,
  parameter int unsigned FAST_DIV  = DefFastDiv,
  parameter int unsigned SLOW_DIV  = DefSlowDiv,
  parameter int unsigned MIN_SLOW  = DefMinSlow,
  parameter int unsigned POS_W     = $clog2(NUM_SYMS * SYM_PITCH),
  parameter int unsigned SYM_W     = $clog2(NUM_SYMS)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_go_fast,
  input  logic             i_go_slow,
  output logic [POS_W-1:0] o_pos,
  output logic [SYM_W-1:0] o_sym,
  output logic             o_busy
);

  localparam int unsigned PH_W = $clog2(SYM_PITCH);
  localparam int unsigned SC_W = $clog2(MIN_SLOW + 1);

  reel_mode_t       r_mode;
  logic [31:0]      r_div;
  logic [PH_W-1:0]  r_phase;
  logic [SYM_W-1:0] r_sym;
  logic [SC_W-1:0]  r_slow;

  logic [31:0]      w_div_max;
  logic             w_step;
  logic             w_phase_wrap;
  logic [PH_W-1:0]  w_phase_nxt;
  logic [SYM_W-1:0] w_sym_nxt;
  logic [SC_W-1:0]  w_slow_nxt;

  always_comb begin
    w_div_max    = (r_mode == ModeSlow) ? 32'(SLOW_DIV - 1) : 32'(FAST_DIV - 1);
    w_step       = (r_mode != ModeStop) && (r_div == w_div_max);
    w_phase_wrap = (r_phase == PH_W'(SYM_PITCH - 1));
    w_phase_nxt  = w_phase_wrap ? '0 : r_phase + 1'b1;
    if (!w_phase_wrap) begin
      w_sym_nxt = r_sym;
    end else if (r_sym == SYM_W'(NUM_SYMS - 1)) begin
      w_sym_nxt = '0;
    end else begin
      w_sym_nxt = r_sym + 1'b1;
    end
    // Saturates at MIN_SLOW, so equality below means "at least MIN_SLOW steps".
    w_slow_nxt = (r_slow == SC_W'(MIN_SLOW)) ? r_slow : r_slow + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mode  <= ModeStop;
      r_div   <= '0;
      r_phase <= '0;
      r_sym   <= '0;
      r_slow  <= '0;
    end else if (i_go_fast && (r_mode == ModeStop)) begin
      r_mode <= ModeFast;
      r_div  <= '0;
    end else if (i_go_slow && (r_mode == ModeFast)) begin
      r_mode <= ModeSlow;
      r_div  <= '0;
      r_slow <= '0;
    end else if (w_step) begin
      r_div   <= '0;
      r_phase <= w_phase_nxt;
      r_sym   <= w_sym_nxt;
      if (r_mode == ModeSlow) begin
        r_slow <= w_slow_nxt;
        if ((w_slow_nxt == SC_W'(MIN_SLOW)) && (w_phase_nxt == '0)) begin
          r_mode <= ModeStop;
        end
      end
    end else if (r_mode != ModeStop) begin
      r_div <= r_div + 32'd1;
    end
  end

  assign o_pos  = POS_W'(32'(r_sym) * SYM_PITCH + 32'(r_phase));
  assign o_sym  = r_sym;
  assign o_busy = (r_mode != ModeStop);

endmodule

// File: rtl/slot_reel_engine.sv
// N-reel spin engine: staggered launch, ordered player stops, abort drain and match result.
module slot_reel_engine
  import slot_pkg::*;
#(
  parameter int unsigned NUM_REELS = DefNumReels,
  parameter int unsigned NUM_SYMS  = DefNumSyms,
  parameter int unsigned SYM_PITCH = DefSymPitch,
  parameter int unsigned FAST_DIV  = DefFastDiv,
  parameter int unsigned SLOW_DIV  = DefSlowDiv,
  parameter int unsigned STAGGER   = DefStagger,
  parameter int unsigned MIN_SLOW  = DefMinSlow,
  parameter int unsigned POS_W     = $clog2(NUM_SYMS * SYM_PITCH),
  parameter int unsigned SYM_W     = $clog2(NUM_SYMS),
  parameter int unsigned MC_W      = $clog2(NUM_REELS + 1)
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_start,
  input  logic                       i_credit_ok,
  input  logic                       i_stop_req,
  input  logic                       i_abort,
  output logic [NUM_REELS*POS_W-1:0] o_reel_pos,
  output logic [NUM_REELS*SYM_W-1:0] o_reel_sym,
  output logic [NUM_REELS-1:0]       o_reel_busy,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_win_all,
  output logic [MC_W-1:0]            o_match_cnt
);

  localparam int unsigned IDX_W = $clog2(NUM_REELS);

  engine_state_t    r_state, w_state_nxt;
  logic [31:0]      r_stag, w_stag_nxt;
  logic [IDX_W-1:0] r_launch_idx, w_launch_nxt;
  logic [IDX_W-1:0] r_stop_idx, w_stop_nxt;
  logic             r_win_all;
  logic [MC_W-1:0]  r_match_cnt;

  logic [NUM_REELS-1:0] w_go_fast;
  logic [NUM_REELS-1:0] w_go_slow;
  logic [NUM_REELS-1:0] w_reel_busy;
  logic                 w_latch_result;
  logic [SYM_W-1:0]     w_sym [NUM_REELS];
  logic [MC_W-1:0]      w_match_cnt;

  for (genvar g = 0; g < NUM_REELS; g++) begin : g_reel
    logic [POS_W-1:0] w_pos;
    slot_reel_channel #(
      .NUM_SYMS (NUM_SYMS),
      .SYM_PITCH(SYM_PITCH),
      .FAST_DIV (FAST_DIV),
      .SLOW_DIV (SLOW_DIV),
      .MIN_SLOW (MIN_SLOW),
      .POS_W    (POS_W),
      .SYM_W    (SYM_W)
    ) u_chan (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_go_fast(w_go_fast[g]),
      .i_go_slow(w_go_slow[g]),
      .o_pos    (w_pos),
      .o_sym    (w_sym[g]),
      .o_busy   (w_reel_busy[g])
    );
    assign o_reel_pos[g*POS_W +: POS_W] = w_pos;
    assign o_reel_sym[g*SYM_W +: SYM_W] = w_sym[g];
  end

  always_comb begin
    w_match_cnt = '0;
    for (int i = 0; i < NUM_REELS; i++) begin
      if (w_sym[i] == w_sym[0]) begin
        w_match_cnt = w_match_cnt + MC_W'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_stag_nxt     = r_stag;
    w_launch_nxt   = r_launch_idx;
    w_stop_nxt     = r_stop_idx;
    w_go_fast      = '0;
    w_go_slow      = '0;
    w_latch_result = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_start && i_credit_ok) begin
          w_go_fast[0] = 1'b1;
          w_launch_nxt = IDX_W'(1);
          w_stag_nxt   = '0;
          w_state_nxt  = StLaunch;
        end
      end
      StLaunch: begin
        // Only FAST reels react to go_slow, so unlaunched reels stay parked.
        if (i_abort) begin
          w_go_slow   = '1;
          w_state_nxt = StDrain;
        end else if (r_stag == 32'(STAGGER - 1)) begin
          w_stag_nxt              = '0;
          w_go_fast[r_launch_idx] = 1'b1;
          w_launch_nxt            = r_launch_idx + 1'b1;
          if (r_launch_idx == IDX_W'(NUM_REELS - 1)) begin
            w_stop_nxt  = '0;
            w_state_nxt = StSpin;
          end
        end else begin
          w_stag_nxt = r_stag + 32'd1;
        end
      end
      StSpin: begin
        if (i_abort) begin
          w_go_slow   = '1;
          w_state_nxt = StDrain;
        end else if (i_stop_req) begin
          w_go_slow[r_stop_idx] = 1'b1;
          w_stop_nxt            = r_stop_idx + 1'b1;
          if (r_stop_idx == IDX_W'(NUM_REELS - 1)) begin
            w_state_nxt = StSettle;
          end
        end
      end
      StSettle: begin
        if (w_reel_busy == '0) begin
          w_latch_result = 1'b1;
          w_state_nxt    = StResult;
        end
      end
      StResult: w_state_nxt = StIdle;
      StDrain: begin
        if (w_reel_busy == '0) begin
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_stag       <= '0;
      r_launch_idx <= '0;
      r_stop_idx   <= '0;
      r_win_all    <= 1'b0;
      r_match_cnt  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_stag       <= w_stag_nxt;
      r_launch_idx <= w_launch_nxt;
      r_stop_idx   <= w_stop_nxt;
      if (w_latch_result) begin
        r_win_all   <= (w_match_cnt == MC_W'(NUM_REELS));
        r_match_cnt <= w_match_cnt;
      end
    end
  end

  assign o_reel_busy = w_reel_busy;
  assign o_busy      = (r_state != StIdle);
  assign o_done      = (r_state == StResult);
  assign o_win_all   = r_win_all;
  assign o_match_cnt = r_match_cnt;

endmodule

// File: tb/tb_slot_reel_engine.sv
// Bench for slot_reel_engine: per-cycle compare against a behavioural game model plus
// directed games with hand-worked reel positions.
module tb_slot_reel_engine;

  localparam int NR = 3, NS = 7, PITCH = 90, FD = 4, SD = 16, STG = 8, MS = 4;
  localparam int STRIP = NS * PITCH;
  localparam int POS_W = 10, SYM_W = 3, MC_W = 2;

  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 1'b0, credit_ok = 1'b0, stop_req = 1'b0, abort = 1'b0;
  logic [NR*POS_W-1:0] reel_pos;
  logic [NR*SYM_W-1:0] reel_sym;
  logic [NR-1:0]       reel_busy;
  logic                busy, done, win_all;
  logic [MC_W-1:0]     match_cnt;

  always #5 clk = ~clk;

  slot_reel_engine #(
    .NUM_REELS(NR), .NUM_SYMS(NS), .SYM_PITCH(PITCH), .FAST_DIV(FD),
    .SLOW_DIV(SD), .STAGGER(STG), .MIN_SLOW(MS)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_credit_ok(credit_ok),
    .i_stop_req(stop_req), .i_abort(abort), .o_reel_pos(reel_pos), .o_reel_sym(reel_sym),
    .o_reel_busy(reel_busy), .o_busy(busy), .o_done(done), .o_win_all(win_all),
    .o_match_cnt(match_cnt)
  );

  int n_checks = 0, n_pass = 0;
  int cyc = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: position as a plain integer on a 630-step ring, mode timers as
  // cycles-since-mode-entry, game progress as counts of launched/stopped reels.
  localparam int MIdle = 0, MLaunch = 1, MSpin = 2, MSettle = 3, MResult = 4, MDrain = 5;
  localparam int RStop = 0, RFast = 1, RSlow = 2;
  int m_pos[NR], m_mode[NR], m_t[NR], m_ns[NR];
  int m_state, m_lc, m_stops, m_win, m_cnt;

  function automatic void m_reset();
    for (int i = 0; i < NR; i++) begin
      m_pos[i] = 0; m_mode[i] = RStop; m_t[i] = 0; m_ns[i] = 0;
    end
    m_state = MIdle; m_lc = 0; m_stops = 0; m_win = 0; m_cnt = 0;
  endfunction

  function automatic bit m_all_stopped();
    for (int i = 0; i < NR; i++) if (m_mode[i] != RStop) return 0;
    return 1;
  endfunction

  function automatic void m_step(input bit s, input bit c, input bit st, input bit ab);
    bit gf[NR], gs[NR];
    int nxt = m_state;
    for (int i = 0; i < NR; i++) begin gf[i] = 0; gs[i] = 0; end
    case (m_state)
      MIdle: if (s && c) begin gf[0] = 1; m_lc = 0; nxt = MLaunch; end
      MLaunch, MSpin: begin
        if (ab) begin
          for (int i = 0; i < NR; i++) gs[i] = 1;
          nxt = MDrain;
        end else if (m_state == MLaunch) begin
          m_lc++;
          if (m_lc % STG == 0) begin
            gf[m_lc / STG] = 1;
            if (m_lc / STG == NR - 1) begin nxt = MSpin; m_stops = 0; end
          end
        end else if (st) begin
          gs[m_stops] = 1;
          m_stops++;
          if (m_stops == NR) nxt = MSettle;
        end
      end
      MSettle: if (m_all_stopped()) begin
        m_cnt = 0;
        for (int i = 0; i < NR; i++) if (m_pos[i] / PITCH == m_pos[0] / PITCH) m_cnt++;
        m_win = (m_cnt == NR);
        nxt = MResult;
      end
      MResult: nxt = MIdle;
      MDrain: if (m_all_stopped()) nxt = MIdle;
      default: nxt = MIdle;
    endcase
    for (int i = 0; i < NR; i++) begin
      if (gf[i] && m_mode[i] == RStop) begin
        m_mode[i] = RFast; m_t[i] = 0;
      end else if (gs[i] && m_mode[i] == RFast) begin
        m_mode[i] = RSlow; m_t[i] = 0; m_ns[i] = 0;
      end else if (m_mode[i] != RStop) begin
        m_t[i]++;
        if (m_t[i] % ((m_mode[i] == RSlow) ? SD : FD) == 0) begin
          m_pos[i] = (m_pos[i] + 1) % STRIP;
          if (m_mode[i] == RSlow) begin
            m_ns[i]++;
            if (m_ns[i] >= MS && m_pos[i] % PITCH == 0) m_mode[i] = RStop;
          end
        end
      end
    end
    m_state = nxt;
  endfunction

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else m_step(start, credit_ok, stop_req, abort);
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Every-cycle comparison against the model, plus a wrap watcher on reel 0.
  initial begin
    int prev0 = -1;
    forever begin
      logic [NR*POS_W-1:0] e_pos;
      logic [NR*SYM_W-1:0] e_sym;
      logic [NR-1:0]       e_busy;
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        e_pos[i*POS_W +: POS_W] = POS_W'(m_pos[i]);
        e_sym[i*SYM_W +: SYM_W] = SYM_W'(m_pos[i] / PITCH);
        e_busy[i]               = (m_mode[i] != RStop);
      end
      check("model_reel_pos", reel_pos, e_pos);
      check("model_reel_sym", reel_sym, e_sym);
      check("model_reel_busy", reel_busy, e_busy);
      check("model_busy", busy, m_state != MIdle);
      check("model_done", done, m_state == MResult);
      check("model_win_all", win_all, m_win);
      check("model_match_cnt", match_cnt, m_cnt);
      if (prev0 == STRIP - 1 && int'(reel_pos[POS_W-1:0]) != STRIP - 1) begin
        check("wrap_pos0", reel_pos[POS_W-1:0], 0);
        check("wrap_sym0", reel_sym[SYM_W-1:0], 0);
      end
      prev0 = int'(reel_pos[POS_W-1:0]);
    end
  end

  // Stimulus helpers: all called at #1 after a rising edge.
  task automatic goto(input int k);
    while (cyc < k) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start(output int e0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    e0 = cyc;
  endtask

  task automatic pulse_stop();
    stop_req = 1'b1;
    @(posedge clk); #1;
    stop_req = 1'b0;
  endtask

  task automatic wait_idle(output int t_stop, output int t_done, output int n_done,
                           output bit r2_moved);
    int n = 0;
    t_stop = -1; t_done = -1; n_done = 0; r2_moved = 0;
    while (busy && n < 5000) begin
      @(posedge clk); #1;
      n++;
      if (reel_busy[2]) r2_moved = 1;
      if (reel_busy == '0 && t_stop < 0) t_stop = cyc;
      if (done) begin n_done++; t_done = cyc; end
    end
    if (busy) check("idle_timeout", busy, 0);
  endtask

  initial begin
    int  e0, t_stop, t_done, n_done;
    bit  seen, r2;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset_pos", reel_pos, 0);
    check("reset_busy", {busy, done, reel_busy}, 0);
    check("reset_result", {win_all, match_cnt}, 0);

    // No credit: start ignored.
    credit_ok = 1'b0;
    pulse_start(e0);
    seen = 0;
    repeat (100) begin @(posedge clk); #1; if (busy) seen = 1; end
    check("no_credit_busy", seen, 0);

    // Game 1: stops at edges 20..22 land every reel on 90 (sym 1).
    credit_ok = 1'b1;
    pulse_start(e0);
    check("stagger_0", reel_busy, 3'b001);
    goto(e0 + 7);  check("stagger_7", reel_busy, 3'b001);
    goto(e0 + 8);  check("stagger_8", reel_busy, 3'b011);
    goto(e0 + 15); check("stagger_15", reel_busy, 3'b011);
    goto(e0 + 16); check("stagger_16", reel_busy, 3'b111);
    goto(e0 + 19);
    stop_req = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    stop_req = 1'b0;
    wait_idle(t_stop, t_done, n_done, r2);
    check("g1_last_stop_cycle", t_stop - e0, 1446);
    check("g1_done_after_stop", t_done - t_stop, 1);
    check("g1_done_once", n_done, 1);
    check("g1_pos", reel_pos, {10'd90, 10'd90, 10'd90});
    check("g1_win_all", win_all, 1);
    check("g1_match_cnt", match_cnt, 3);

    // Game 2: reels 0/1 snap to 180, reel 2 to 270 -> syms {2,2,3}.
    pulse_start(e0);
    goto(e0 + 199); pulse_stop();
    pulse_stop();
    goto(e0 + 599); pulse_stop();
    wait_idle(t_stop, t_done, n_done, r2);
    check("g2_done_once", n_done, 1);
    check("g2_sym", reel_sym, {3'd3, 3'd2, 3'd2});
    check("g2_pos", reel_pos, {10'd270, 10'd180, 10'd180});
    check("g2_win_all", win_all, 0);
    check("g2_match_cnt", match_cnt, 2);

    // Abort after two launches: reel 2 parked, reels 0/1 snap to 270, result held.
    pulse_start(e0);
    goto(e0 + 9);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    wait_idle(t_stop, t_done, n_done, r2);
    check("abort_no_done", n_done, 0);
    check("abort_reel2_idle", r2, 0);
    check("abort_pos", reel_pos, {10'd270, 10'd270, 10'd270});
    check("abort_busy", busy, 0);
    check("abort_hold_result", {win_all, match_cnt}, {1'b0, 2'd2});

    // Reset mid-spin clears everything immediately.
    pulse_start(e0);
    goto(e0 + 20);
    check("pre_reset_busy", reel_busy, 3'b111);
    rst_n = 1'b0;
    #1;
    check("midreset_pos", reel_pos, 0);
    check("midreset_flags", {busy, done, reel_busy}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    seen = 0;
    repeat (50) begin @(posedge clk); #1; if (done || busy) seen = 1; end
    check("midreset_quiet", seen, 0);

    // Random play, checked cycle-by-cycle against the model.
    repeat (30000) begin
      start     = ($urandom_range(0, 39) == 0);
      credit_ok = ($urandom_range(0, 3) != 0);
      stop_req  = ($urandom_range(0, 24) == 0);
      abort     = ($urandom_range(0, 599) == 0);
      @(posedge clk); #1;
    end
    {start, stop_req, abort} = '0;
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
